// File: rtl/stack_ctrl_16b.sv
// Stack-pointer sequencer: round-robin push/pop arbitration, single-port stack memory sequencing, occupancy tracking.
// Optional peek requester enabled by defining STACK_PEEK_EN.
module stack_ctrl_16b #(
    parameter logic [15:0] BASE  = 16'hFFFF,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = 9
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        push_req,
    input  logic [15:0] push_data,
    input  logic        pop_req,
`ifdef STACK_PEEK_EN
    input  logic        peek_req,
    output logic        peek_ack,
`endif
    output logic        push_ack,
    output logic        pop_ack,
    output logic [15:0] pop_data,
    output logic        err,
    output logic        full,
    output logic        empty,
    input  logic [15:0] dp,
    output logic [15:0] dp_add,
    output logic [1:0]  dp_src,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] SRC_HOLD = 2'b00;
    localparam logic [1:0] SRC_INC  = 2'b01;
    localparam logic [1:0] SRC_DEC  = 2'b10;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_PUSH_WR,
        S_PUSH_DEC,
        S_POP_INC,
        S_POP_RD,
        S_POP_DONE,
        S_PEEK_DEC,
        S_ERR_PUSH,
        S_ERR_POP,
        S_ERR_PEEK
    } state_e;

    typedef enum logic [1:0] {
        REQ_PUSH = 2'd0,
        REQ_POP  = 2'd1,
        REQ_PEEK = 2'd2
    } req_e;

    state_e             state_q;
    req_e               rr_q;
    req_e               rr_d;
    req_e               grant_d;
    logic               grant_vld_d;
    logic               peek_q;
    logic [CNT_W-1:0]   count_q;
    logic [15:0]        pop_hold_q;
    logic               peek_req_w;

`ifdef STACK_PEEK_EN
    assign peek_req_w = peek_req;
`else
    assign peek_req_w = 1'b0;
`endif

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_wdata = push_data;

    // Round-robin: search starts at rr_q, then rr_q moves past the winner.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_d     = REQ_PUSH;
        case (rr_q)
            REQ_POP: begin
                if (pop_req) begin
                    grant_vld_d = 1'b1; grant_d = REQ_POP;
                end else if (peek_req_w) begin
                    grant_vld_d = 1'b1; grant_d = REQ_PEEK;
                end else if (push_req) begin
                    grant_vld_d = 1'b1; grant_d = REQ_PUSH;
                end
            end
            REQ_PEEK: begin
                if (peek_req_w) begin
                    grant_vld_d = 1'b1; grant_d = REQ_PEEK;
                end else if (push_req) begin
                    grant_vld_d = 1'b1; grant_d = REQ_PUSH;
                end else if (pop_req) begin
                    grant_vld_d = 1'b1; grant_d = REQ_POP;
                end
            end
            default: begin
                if (push_req) begin
                    grant_vld_d = 1'b1; grant_d = REQ_PUSH;
                end else if (pop_req) begin
                    grant_vld_d = 1'b1; grant_d = REQ_POP;
                end else if (peek_req_w) begin
                    grant_vld_d = 1'b1; grant_d = REQ_PEEK;
                end
            end
        endcase

        rr_d = rr_q;
        if (grant_vld_d) begin
            case (grant_d)
                REQ_PUSH: rr_d = REQ_POP;
`ifdef STACK_PEEK_EN
                REQ_POP:  rr_d = REQ_PEEK;
`else
                REQ_POP:  rr_d = REQ_PUSH;
`endif
                default:  rr_d = REQ_PUSH;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            rr_q       <= REQ_PUSH;
            peek_q     <= 1'b0;
            count_q    <= '0;
            pop_hold_q <= '0;
        end else begin
            case (state_q)
                S_INIT: state_q <= S_IDLE;
                S_IDLE: begin
                    if (grant_vld_d) begin
                        rr_q   <= rr_d;
                        peek_q <= (grant_d == REQ_PEEK);
                        case (grant_d)
                            REQ_PUSH: state_q <= full  ? S_ERR_PUSH : S_PUSH_WR;
                            REQ_POP:  state_q <= empty ? S_ERR_POP  : S_POP_INC;
                            default:  state_q <= empty ? S_ERR_PEEK : S_POP_INC;
                        endcase
                    end
                end
                S_PUSH_WR: state_q <= S_PUSH_DEC;
                S_PUSH_DEC: begin
                    count_q <= count_q + CNT_W'(1);
                    state_q <= S_IDLE;
                end
                S_POP_INC: begin
                    // A peek borrows the pop read path but leaves occupancy alone.
                    if (!peek_q) begin
                        count_q <= count_q - CNT_W'(1);
                    end
                    state_q <= S_POP_RD;
                end
                S_POP_RD: state_q <= peek_q ? S_PEEK_DEC : S_POP_DONE;
                S_POP_DONE, S_PEEK_DEC: begin
                    pop_hold_q <= mem_rdata;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        dp_add   = dp;
        dp_src   = SRC_HOLD;
        mem_addr = dp;
        mem_we   = 1'b0;
        push_ack = 1'b0;
        pop_ack  = 1'b0;
        err      = 1'b0;
        pop_data = pop_hold_q;
`ifdef STACK_PEEK_EN
        peek_ack = 1'b0;
`endif
        case (state_q)
            S_INIT:     dp_add = BASE;
            S_PUSH_WR:  mem_we = 1'b1;
            S_PUSH_DEC: begin
                dp_src   = SRC_DEC;
                push_ack = 1'b1;
            end
            S_POP_INC:  dp_src = SRC_INC;
            S_POP_DONE: begin
                pop_ack  = 1'b1;
                pop_data = mem_rdata;
            end
            S_PEEK_DEC: begin
                dp_src   = SRC_DEC;
                pop_data = mem_rdata;
`ifdef STACK_PEEK_EN
                peek_ack = 1'b1;
`endif
            end
            S_ERR_PUSH: begin
                push_ack = 1'b1;
                err      = 1'b1;
            end
            S_ERR_POP: begin
                pop_ack = 1'b1;
                err     = 1'b1;
            end
            S_ERR_PEEK: begin
                err = 1'b1;
`ifdef STACK_PEEK_EN
                peek_ack = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl_16b.sv
// Bench for stack_ctrl_16b: datapath and memory models, a transaction-level stack model and a per-cycle compare.
module tb_stack_ctrl_16b;

    localparam logic [15:0] BASE  = 16'h00FF;
    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        push_req = 1'b0;
    logic [15:0] push_data = '0;
    logic        pop_req = 1'b0;
    logic        push_ack, pop_ack, err, full, empty, mem_we;
    logic [15:0] pop_data, dp_add, mem_addr, mem_wdata;
    logic [1:0]  dp_src;
    logic [15:0] dp = '0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem [0:65535];

    always #5 CLK = ~CLK;

    stack_ctrl_16b #(.BASE(BASE), .DEPTH(DEPTH), .CNT_W(3)) dut (
        .CLK(CLK), .reset(reset),
        .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
        .push_ack(push_ack), .pop_ack(pop_ack), .pop_data(pop_data), .err(err),
        .full(full), .empty(empty),
        .dp(dp), .dp_add(dp_add), .dp_src(dp_src),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // External pointer datapath and synchronous single-port memory.
    always @(posedge CLK) begin
        case (dp_src)
            2'b01:   dp <= dp_add + 16'd1;
            2'b10:   dp <= dp_add - 16'd1;
            default: dp <= dp_add;
        endcase
    end

    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        pa, pp, er, we, ca;
        logic [15:0] addr, wd, pd, dp;
        int          n;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    exp_t        exp_q[$];
    int          n = 0;
    logic [15:0] stk[$];
    logic [15:0] hold = '0;
    bit          last_push = 1'b0;

    function automatic logic [15:0] sp(input int k);
        return BASE - 16'(k);
    endfunction

    function automatic exp_t quiet_e();
        exp_t r;
        r.pa = 1'b0; r.pp = 1'b0; r.er = 1'b0; r.we = 1'b0; r.ca = 1'b0;
        r.addr = '0; r.wd = '0; r.pd = hold; r.dp = sp(n); r.n = n;
        return r;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle compare against scheduled transaction cycles or the idle expectation.
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = quiet_e();
                check1("push_ack", push_ack, e.pa);
                check1("pop_ack", pop_ack, e.pp);
                check1("err", err, e.er);
                check1("mem_we", mem_we, e.we);
                if (e.we) check16("mem_wdata", mem_wdata, e.wd);
                if (e.ca) check16("mem_addr", mem_addr, e.addr);
                check1("full", full, e.n == DEPTH);
                check1("empty", empty, e.n == 0);
                check16("dp", dp, e.dp);
                check16("pop_data", pop_data, e.pd);
                check1("dp_src_legal", dp_src == 2'b11, 1'b0);
            end
        end
    end

    // Issue a request from an idle cycle and schedule the expected cycles that follow.
    task automatic run_op(input bit rq_push, input bit rq_pop, input logic [15:0] v, input bit keep);
        exp_t e;
        bit   g_push;
        int   len;
        push_req  = rq_push;
        pop_req   = rq_pop;
        push_data = v;
        g_push    = rq_push && (!rq_pop || !last_push);
        last_push = g_push;
        if (g_push) begin
            if (n < DEPTH) begin
                e = quiet_e(); e.we = 1'b1; e.ca = 1'b1; e.addr = sp(n); e.wd = v;
                exp_q.push_back(e);
                e = quiet_e(); e.pa = 1'b1;
                exp_q.push_back(e);
                stk.push_back(v); n++; len = 2;
            end else begin
                e = quiet_e(); e.pa = 1'b1; e.er = 1'b1;
                exp_q.push_back(e); len = 1;
            end
        end else begin
            if (n > 0) begin
                e = quiet_e();
                exp_q.push_back(e);
                e.n = n - 1; e.dp = sp(n - 1); e.ca = 1'b1; e.addr = sp(n - 1);
                exp_q.push_back(e);
                e.ca = 1'b0; e.pp = 1'b1; e.pd = stk[$];
                exp_q.push_back(e);
                hold = stk.pop_back(); n--; len = 3;
            end else begin
                e = quiet_e(); e.pp = 1'b1; e.er = 1'b1;
                exp_q.push_back(e); len = 1;
            end
        end
        repeat (len) @(negedge CLK);
        #1;
        if (!keep) begin
            push_req = 1'b0;
            pop_req  = 1'b0;
        end
        @(negedge CLK);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        #1;
        check16("reset_dp", dp, 16'h00FF);
        check1("reset_empty", empty, 1'b1);
        check1("reset_full", full, 1'b0);
        check1("reset_push_ack", push_ack, 1'b0);
        check1("reset_pop_ack", pop_ack, 1'b0);
        check16("reset_pop_data", pop_data, 16'h0000);
        chk_en = 1'b1;

        run_op(1'b1, 1'b0, 16'hA5A5, 1'b0);
        check16("push_mem_00ff", mem[16'h00FF], 16'hA5A5);
        check16("push_dp", dp, 16'h00FE);
        run_op(1'b0, 1'b1, 16'h0000, 1'b0);
        check16("pop_a5a5_held", pop_data, 16'hA5A5);

        for (int i = 1; i <= 4; i++) run_op(1'b1, 1'b0, 16'(i), 1'b0);
        check1("full_after_4", full, 1'b1);
        check16("mem_00fc", mem[16'h00FC], 16'h0004);
        run_op(1'b1, 1'b0, 16'hDEAD, 1'b0);
        check16("overflow_dp", dp, 16'h00FB);

        for (int i = 0; i < 5; i++) run_op(1'b0, 1'b1, 16'h0000, 1'b0);
        check16("underflow_pop_data", pop_data, 16'h0001);
        check16("underflow_dp", dp, 16'h00FF);

        run_op(1'b1, 1'b0, 16'h1111, 1'b0);
        run_op(1'b1, 1'b0, 16'h2222, 1'b0);
        run_op(1'b1, 1'b0, 16'h3333, 1'b0);
        run_op(1'b0, 1'b1, 16'h0000, 1'b0);
        run_op(1'b1, 1'b1, 16'h4444, 1'b1);
        run_op(1'b1, 1'b1, 16'h4444, 1'b1);
        run_op(1'b1, 1'b1, 16'h5555, 1'b1);
        run_op(1'b1, 1'b1, 16'h5555, 1'b0);
        check16("rr_last_pop", pop_data, 16'h5555);
        check16("rr_dp", dp, 16'h00FD);

        // Reset while a write is in flight.
        chk_en    = 1'b0;
        push_req  = 1'b1;
        push_data = 16'h7777;
        @(negedge CLK);
        #1;
        check1("pre_reset_mem_we", mem_we, 1'b1);
        reset = 1'b1;
        #1;
        check1("rst_mem_we", mem_we, 1'b0);
        check16("rst_dp_add", dp_add, 16'h00FF);
        check1("rst_empty", empty, 1'b1);
        push_req = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        n = 0; stk.delete(); hold = '0; last_push = 1'b0;
        @(negedge CLK);
        #1;
        check16("rst2_dp", dp, 16'h00FF);
        check1("rst2_empty", empty, 1'b1);
        chk_en = 1'b1;
        run_op(1'b0, 1'b1, 16'h0000, 1'b0);
        run_op(1'b1, 1'b0, 16'hBEEF, 1'b0);
        run_op(1'b0, 1'b1, 16'h0000, 1'b0);
        check16("final_pop", pop_data, 16'hBEEF);

        repeat (3) @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
